// File: rtl/issue_pkg.sv
// issue_pkg: shared defaults, wrap-safe age compare and per-source entry type for the issue window
package issue_pkg;
    localparam int DEPTH_DEF     = 16;
    localparam int NUM_SRC_DEF   = 3;
    localparam int NUM_BCAST_DEF = 2;
    localparam int TAG_W_DEF     = 6;
    localparam int DATA_W_DEF    = 32;
    localparam int PAYLOAD_W_DEF = 138;
    localparam int SEQ_W_DEF     = 32;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic                  rdy;
        logic [DATA_W_DEF-1:0] val;
    } src_t;

    // a is older than b when (a - b) is negative in SEQ_W arithmetic
    function automatic logic older(input logic [SEQ_W_DEF-1:0] a, input logic [SEQ_W_DEF-1:0] b);
        logic [SEQ_W_DEF-1:0] d;
        d = a - b;
        return d[SEQ_W_DEF-1];
    endfunction
endpackage

// File: rtl/issue_window_age_select.sv
// age_select: one-hot grant to the oldest eligible entry, purely combinational
module age_select
    import issue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int SEQ_W = SEQ_W_DEF
) (
    input  logic [DEPTH-1:0] elig_i,
    input  logic [SEQ_W-1:0] seq_i [DEPTH],
    output logic [DEPTH-1:0] grant_o,
    output logic             any_o
);
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = elig_i[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && elig_i[j] && !older(seq_i[i], seq_i[j])) grant_o[i] = 1'b0;
        end
    end

    assign any_o = |elig_i;
endmodule

// File: rtl/issue_window.sv
// issue_window: out-of-order issue window with broadcast wakeup, oldest-first select
// and a valid/ready output register honouring ROB-head serialisation and flush.
module issue_window
    import issue_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int NUM_BCAST = NUM_BCAST_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int SEQ_W     = SEQ_W_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          enq_valid_i,
    output logic                          enq_ready_o,
    input  logic [PAYLOAD_W-1:0]          enq_payload_i,
    input  logic [SEQ_W-1:0]              enq_seq_i,
    input  logic                          enq_serial_i,
    input  logic [NUM_SRC*TAG_W-1:0]      enq_src_tag_i,
    input  logic [NUM_SRC-1:0]            enq_src_rdy_i,
    input  logic [NUM_SRC*DATA_W-1:0]     enq_src_val_i,
    input  logic [SEQ_W-1:0]              rob_head_seq_i,
    input  logic [NUM_BCAST-1:0]          bc_valid_i,
    input  logic [NUM_BCAST*TAG_W-1:0]    bc_tag_i,
    input  logic [NUM_BCAST*DATA_W-1:0]   bc_val_i,
    output logic                          iss_valid_o,
    input  logic                          iss_ready_i,
    output logic [PAYLOAD_W-1:0]          iss_payload_o,
    output logic [SEQ_W-1:0]              iss_seq_o,
    output logic [NUM_SRC*DATA_W-1:0]     iss_src_val_o,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy_o
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]          valid_q, valid_d, serial_q, serial_d, elig, grant, free_oh;
    logic [PAYLOAD_W-1:0]      payload_q [DEPTH], payload_d [DEPTH];
    logic [SEQ_W-1:0]          seq_q [DEPTH], seq_d [DEPTH];
    src_t                      src_q [DEPTH][NUM_SRC], src_d [DEPTH][NUM_SRC];
    logic                      iss_valid_q, iss_valid_d, any_grant, do_enq, adv;
    logic [PAYLOAD_W-1:0]      iss_payload_q, iss_payload_d;
    logic [SEQ_W-1:0]          iss_seq_q, iss_seq_d;
    logic [NUM_SRC*DATA_W-1:0] iss_val_q, iss_val_d;
    logic [OCC_W-1:0]          occ;

    // Lowest-numbered broadcast channel wins; ready sources and tag 0 are never touched
    function automatic src_t wake(input src_t s, input logic [NUM_BCAST-1:0] v,
                                  input logic [NUM_BCAST*TAG_W-1:0] t,
                                  input logic [NUM_BCAST*DATA_W-1:0] d);
        wake = s;
        for (int k = NUM_BCAST-1; k >= 0; k--)
            if (!s.rdy && s.tag != '0 && v[k] && t[k*TAG_W +: TAG_W] == s.tag) begin
                wake.rdy = 1'b1;
                wake.val = d[k*DATA_W +: DATA_W];
            end
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(valid_q[i]);
    end

    assign free_oh     = ~valid_q & (valid_q + DEPTH'(1));
    assign enq_ready_o = occ < OCC_W'(DEPTH);
    assign do_enq      = enq_valid_i & enq_ready_o & ~flush_i;
    assign adv         = (~iss_valid_q | iss_ready_i) & ~flush_i;

    always_comb begin
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = valid_q[i] & (~serial_q[i] | (seq_q[i] == rob_head_seq_i));
            for (int s = 0; s < NUM_SRC; s++) elig[i] = elig[i] & src_q[i][s].rdy;
        end
    end

    age_select #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_sel (
        .elig_i  (elig),
        .seq_i   (seq_q),
        .grant_o (grant),
        .any_o   (any_grant)
    );

    always_comb begin
        valid_d       = valid_q;
        serial_d      = serial_q;
        payload_d     = payload_q;
        seq_d         = seq_q;
        src_d         = src_q;
        iss_valid_d   = iss_valid_q;
        iss_payload_d = iss_payload_q;
        iss_seq_d     = iss_seq_q;
        iss_val_d     = iss_val_q;
        for (int i = 0; i < DEPTH; i++)
            for (int s = 0; s < NUM_SRC; s++)
                if (valid_q[i]) src_d[i][s] = wake(src_q[i][s], bc_valid_i, bc_tag_i, bc_val_i);
        if (adv) begin
            iss_valid_d = any_grant;
            for (int i = 0; i < DEPTH; i++)
                if (grant[i]) begin
                    valid_d[i]    = 1'b0;
                    iss_payload_d = payload_q[i];
                    iss_seq_d     = seq_q[i];
                    for (int s = 0; s < NUM_SRC; s++) iss_val_d[s*DATA_W +: DATA_W] = src_q[i][s].val;
                end
        end
        // free_oh comes from registered valids, so a slot vacated this edge stays empty
        for (int i = 0; i < DEPTH; i++)
            if (do_enq && free_oh[i]) begin
                valid_d[i]   = 1'b1;
                serial_d[i]  = enq_serial_i;
                payload_d[i] = enq_payload_i;
                seq_d[i]     = enq_seq_i;
                for (int s = 0; s < NUM_SRC; s++)
                    src_d[i][s] = wake('{tag: enq_src_tag_i[s*TAG_W +: TAG_W],
                                         rdy: enq_src_rdy_i[s] | (enq_src_tag_i[s*TAG_W +: TAG_W] == '0),
                                         val: enq_src_val_i[s*DATA_W +: DATA_W]},
                                       bc_valid_i, bc_tag_i, bc_val_i);
            end
        if (flush_i) begin
            valid_d     = '0;
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            serial_q      <= '0;
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_seq_q     <= '0;
            iss_val_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
                seq_q[i]     <= '0;
                for (int s = 0; s < NUM_SRC; s++) src_q[i][s] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            serial_q      <= serial_d;
            payload_q     <= payload_d;
            seq_q         <= seq_d;
            src_q         <= src_d;
            iss_valid_q   <= iss_valid_d;
            iss_payload_q <= iss_payload_d;
            iss_seq_q     <= iss_seq_d;
            iss_val_q     <= iss_val_d;
        end
    end

    assign iss_valid_o   = iss_valid_q;
    assign iss_payload_o = iss_payload_q;
    assign iss_seq_o     = iss_seq_q;
    assign iss_src_val_o = iss_val_q;
    assign occupancy_o   = occ;
endmodule
